// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file for the pipelined datapath. The writeback stage
// drives two write ports; the decode stage reads through NUM_RD asynchronous
// read ports. After every reset a clear engine zeroes one entry per clock
// and holds busy high until the whole array is clean.
//
// Ports
//   clk     : rising-edge clock
//   reset   : synchronous, active-high reset (starts the clear sequence)
//   wrtEn0  : write enable, port 0
//   dr0     : destination register, port 0
//   dIn0    : write data, port 0
//   wrtEn1  : write enable, port 1 (wins over port 0 on the same address)
//   dr1     : destination register, port 1
//   dIn1    : write data, port 1
//   rdAddr  : packed read addresses, lane k at [k*REG_WIDTH +: REG_WIDTH]
//   rdData  : packed read data, lane k at [k*BIT_WIDTH +: BIT_WIDTH]
//   busy    : clear sequence in progress (writes ignored, reads return 0)
module regfile_mp #(
  parameter int BIT_WIDTH = 32,
  parameter int REG_WIDTH = 4,
  parameter int REG_SIZE  = 1 << REG_WIDTH,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wrtEn0,
  input  logic [REG_WIDTH-1:0]          dr0,
  input  logic [BIT_WIDTH-1:0]          dIn0,
  input  logic                          wrtEn1,
  input  logic [REG_WIDTH-1:0]          dr1,
  input  logic [BIT_WIDTH-1:0]          dIn1,
  input  logic [NUM_RD*REG_WIDTH-1:0]   rdAddr,
  output logic [NUM_RD*BIT_WIDTH-1:0]   rdData,
  output logic                          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               r_state;
  logic [REG_WIDTH-1:0] r_clrIdx;
  logic                 r_busy;
  logic [BIT_WIDTH-1:0] r_regs [REG_SIZE];

  logic                 w_wr0;
  logic                 w_wr1;
  logic                 w_lastClr;

  // Writes aimed at the hardwired zero register are dropped here so the
  // array never has to be special-cased on the read side beyond address 0.
  assign w_wr0     = wrtEn0 && !((ZERO_REG != 0) && (dr0 == '0));
  assign w_wr1     = wrtEn1 && !((ZERO_REG != 0) && (dr1 == '0));
  assign w_lastClr = (r_clrIdx == REG_WIDTH'(REG_SIZE - 1));

  // Control FSM, clear engine and write ports share one clocked block.
  // Reset only rewinds the clear engine; the array itself is zeroed one
  // entry per edge afterwards, and a reset during clearing restarts at 0.
  // In IDLE port 1 is written after port 0, so on a shared address the
  // later non-blocking assignment (port 1) is the one that sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= CLEAR;
      r_clrIdx <= '0;
      r_busy   <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_regs[r_clrIdx] <= '0;
          if (w_lastClr) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clrIdx <= r_clrIdx + 1'b1;
          end
        end
        default: begin
          if (w_wr0) begin
            r_regs[dr0] <= dIn0;
          end
          if (w_wr1) begin
            r_regs[dr1] <= dIn1;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;

  // One combinational read lane per port. Priority: busy blanks the lane,
  // then the zero register, then bypass from port 1, then port 0, and
  // finally the stored value.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [REG_WIDTH-1:0] w_addr;
    logic [BIT_WIDTH-1:0] w_data;

    assign w_addr = rdAddr[k*REG_WIDTH +: REG_WIDTH];

    always_comb begin
      w_data = r_regs[w_addr];
      if (r_busy) begin
        w_data = '0;
      end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_data = '0;
      end else if ((BYPASS != 0) && wrtEn1 && (dr1 == w_addr)) begin
        w_data = dIn1;
      end else if ((BYPASS != 0) && wrtEn0 && (dr0 == w_addr)) begin
        w_data = dIn0;
      end
    end

    assign rdData[k*BIT_WIDTH +: BIT_WIDTH] = w_data;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances share the write and read
// stimulus: dutA (4 read lanes, bypass on) and dutB (2 read lanes, bypass
// off), both with the zero register enabled. A behavioural model of the
// register file is checked against both on every cycle, and a set of
// hand-computed literal expectations pins the model itself.
module tb_regfile_mp;

  localparam int BW = 32;
  localparam int RW = 4;
  localparam int NR = 16;

  logic          clk;
  logic          reset;
  logic          wrtEn0;
  logic [RW-1:0] dr0;
  logic [BW-1:0] dIn0;
  logic          wrtEn1;
  logic [RW-1:0] dr1;
  logic [BW-1:0] dIn1;
  logic [4*RW-1:0] rdAddr;
  logic [4*BW-1:0] rdDataA;
  logic [2*BW-1:0] rdDataB;
  logic          busyA;
  logic          busyB;

  int checks = 0;
  int fails  = 0;

  logic [BW-1:0] modelRegs [NR];
  int            busyLeft  = 0;
  bit            modelKnown = 0;

  regfile_mp #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .NUM_RD(4),
               .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk(clk), .reset(reset),
    .wrtEn0(wrtEn0), .dr0(dr0), .dIn0(dIn0),
    .wrtEn1(wrtEn1), .dr1(dr1), .dIn1(dIn1),
    .rdAddr(rdAddr), .rdData(rdDataA), .busy(busyA)
  );

  regfile_mp #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .NUM_RD(2),
               .ZERO_REG(1), .BYPASS(0)) dutB (
    .clk(clk), .reset(reset),
    .wrtEn0(wrtEn0), .dr0(dr0), .dIn0(dIn0),
    .wrtEn1(wrtEn1), .dr1(dr1), .dIn1(dIn1),
    .rdAddr(rdAddr[2*RW-1:0]), .rdData(rdDataB), .busy(busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a reset edge arms a 16-edge clear countdown; when it
  // expires the whole array is zero. Outside the countdown writes land,
  // port 1 after port 0, and address 0 never changes.
  always @(posedge clk) begin
    if (reset) begin
      modelKnown <= 1'b1;
      busyLeft   <= NR;
    end else if (busyLeft > 0) begin
      busyLeft <= busyLeft - 1;
      if (busyLeft == 1) begin
        for (int i = 0; i < NR; i++) modelRegs[i] <= '0;
      end
    end else if (modelKnown) begin
      if (wrtEn0 && dr0 != 0) modelRegs[dr0] <= dIn0;
      if (wrtEn1 && dr1 != 0) modelRegs[dr1] <= dIn1;
    end
  end

  function automatic logic [BW-1:0] expRead(input logic [RW-1:0] a, input bit byp);
    if (busyLeft > 0)                 return '0;
    if (a == 0)                       return '0;
    if (byp && wrtEn1 && dr1 == a)    return dIn1;
    if (byp && wrtEn0 && dr0 == a)    return dIn0;
    return modelRegs[a];
  endfunction

  task automatic checkOutput(input string name, input logic [BW-1:0] act,
                             input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled after the inputs for
  // the cycle have settled (one time unit past the falling edge).
  always @(negedge clk) begin
    #1;
    if (modelKnown) begin
      checkOutput("busyA", {31'b0, busyA}, {31'b0, busyLeft > 0});
      checkOutput("busyB", {31'b0, busyB}, {31'b0, busyLeft > 0});
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("laneA%0d", k), rdDataA[k*BW +: BW],
                    expRead(rdAddr[k*RW +: RW], 1'b1));
      for (int k = 0; k < 2; k++)
        checkOutput($sformatf("laneB%0d", k), rdDataB[k*BW +: BW],
                    expRead(rdAddr[k*RW +: RW], 1'b0));
    end
  end

  task automatic applyStimulus(input logic we0, input logic [RW-1:0] a0,
                               input logic [BW-1:0] d0, input logic we1,
                               input logic [RW-1:0] a1, input logic [BW-1:0] d1,
                               input logic [4*RW-1:0] addrs);
    @(negedge clk);
    wrtEn0 = we0; dr0 = a0; dIn0 = d0;
    wrtEn1 = we1; dr1 = a1; dIn1 = d1;
    rdAddr = addrs;
    #1;
  endtask

  task automatic idleRead(input logic [4*RW-1:0] addrs);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, addrs);
  endtask

  // Counts edges from now until busy drops, bounded so a stuck clear
  // engine shows up as a failed comparison instead of a hang. An optional
  // write is attempted on the third edge of the wait.
  task automatic waitClear(input string name, input bit tryWrite);
    int cnt = 0;
    while (busyA && cnt < 40) begin
      @(negedge clk);
      wrtEn0 = tryWrite && (cnt == 2);
      dr0    = 4'd7;
      dIn0   = 32'h0000_0077;
      #1;
      cnt++;
    end
    wrtEn0 = 1'b0;
    checkOutput(name, cnt, 16);
  endtask

  initial begin
    reset = 1'b1;
    wrtEn0 = 1'b0; dr0 = '0; dIn0 = '0;
    wrtEn1 = 1'b0; dr1 = '0; dIn1 = '0;
    rdAddr = '0;

    // Power-on clear.
    @(negedge clk);
    #1;
    checkOutput("resetBusy", {31'b0, busyA}, 32'd1);
    checkOutput("resetLane", rdDataA[BW-1:0], 32'd0);
    reset = 1'b0;
    waitClear("initClearLen", 1'b0);

    // Test 1: r5 survives until a reset clears it; a write during busy is lost.
    applyStimulus(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, {4'd0, 4'd0, 4'd0, 4'd5});
    idleRead({4'd0, 4'd0, 4'd0, 4'd5});
    checkOutput("r5Written", rdDataA[BW-1:0], 32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    waitClear("clearLen", 1'b1);
    idleRead({4'd0, 4'd0, 4'd7, 4'd5});
    checkOutput("r5Cleared", rdDataA[BW-1:0], 32'd0);
    checkOutput("busyWriteLost", rdDataA[BW +: BW], 32'd0);

    // Test 2: fill the array, then reset again partway through the clear.
    for (int i = 1; i < NR; i++)
      applyStimulus(1'b1, RW'(i), 32'h1111 * i, 1'b0, '0, '0, '0);
    idleRead({4'd0, 4'd0, 4'd0, 4'd12});
    checkOutput("r12Filled", rdDataA[BW-1:0], 32'h0000_CCCC);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    waitClear("midClearLen", 1'b0);
    for (int i = 0; i < NR; i += 4) begin
      idleRead({RW'(i + 3), RW'(i + 2), RW'(i + 1), RW'(i)});
      checkOutput($sformatf("allZero%0d", i), rdDataA[BW-1:0] | rdDataA[BW +: BW]
                  | rdDataA[2*BW +: BW] | rdDataA[3*BW +: BW], 32'd0);
    end

    // Test 3: write collision, then two independent writes.
    applyStimulus(1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22, '0);
    idleRead({4'd0, 4'd6, 4'd4, 4'd3});
    checkOutput("collision", rdDataA[BW-1:0], 32'h22);
    applyStimulus(1'b1, 4'd4, 32'hAA, 1'b1, 4'd6, 32'hBB, {4'd0, 4'd6, 4'd4, 4'd3});
    idleRead({4'd0, 4'd6, 4'd4, 4'd3});
    checkOutput("dualR4", rdDataA[BW +: BW], 32'hAA);
    checkOutput("dualR6", rdDataA[2*BW +: BW], 32'hBB);

    // Test 4: bypass on dutA, no bypass on dutB.
    applyStimulus(1'b1, 4'd9, 32'h1, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 4'd9, 32'h55, 1'b0, '0, '0, {4'd9, 4'd9, 4'd9, 4'd9});
    checkOutput("bypassA", rdDataA[BW-1:0], 32'h55);
    checkOutput("noBypassB", rdDataB[BW-1:0], 32'h1);
    idleRead({4'd9, 4'd9, 4'd9, 4'd9});
    checkOutput("afterWriteB", rdDataB[BW-1:0], 32'h55);

    // Test 5: register 0 ignores writes and reads 0 even with bypass.
    applyStimulus(1'b1, 4'd0, 32'hFFFF, 1'b1, 4'd0, 32'hFFFF, '0);
    checkOutput("zeroBypassA", rdDataA[3*BW +: BW] | rdDataA[BW-1:0], 32'd0);
    checkOutput("zeroB", rdDataB[BW +: BW], 32'd0);
    idleRead('0);
    checkOutput("zeroAfter", rdDataA[2*BW +: BW], 32'd0);

    // Test 6: four lanes, two of them on the same register.
    applyStimulus(1'b1, 4'd1, 32'h10, 1'b1, 4'd2, 32'h20, '0);
    applyStimulus(1'b1, 4'd15, 32'hF0, 1'b0, '0, '0, '0);
    idleRead({4'd15, 4'd1, 4'd2, 4'd1});
    checkOutput("lane0", rdDataA[BW-1:0], 32'h10);
    checkOutput("lane1", rdDataA[BW +: BW], 32'h20);
    checkOutput("lane2", rdDataA[2*BW +: BW], 32'h10);
    checkOutput("lane3", rdDataA[3*BW +: BW], 32'hF0);
    checkOutput("laneB1", rdDataB[BW +: BW], 32'h20);

    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
